// File: rtl/button_direction_ctrl.sv
// Debounced 4-button direction controller: one-hot move pulse per clean press, gated by game status.
// Optional auto-repeat while a single button is held: define DIR_AUTOREPEAT_EN.
module button_direction_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_raw,
  input  logic [1:0]  game_state,
  output logic [3:0]  direction,
  output logic [3:0]  btn_stable,
  output logic [15:0] move_count
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  // Cycles from reset release until a button held through reset is guaranteed visible in btn_stable.
  localparam int unsigned SETTLE = DEBOUNCE_CYCLES + 3;
  localparam int unsigned ST_W   = $clog2(SETTLE + 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("button_direction_ctrl: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [3:0]      sync1_q, sync1_d;
  logic [3:0]      sync2_q, sync2_d;
  logic [3:0]      stable_q, stable_d;
  logic [3:0]      dir_q, dir_d;
  logic [15:0]     mc_q, mc_d;
  logic [ST_W-1:0] settle_q, settle_d;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];
  logic            one_hot, playing, settled;

`ifdef DIR_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [3:0]       held_q, held_d;
  logic             rpt_hold;
`endif

  // Two-flop synchronizer
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Per-bit debounce: level must differ for DEBOUNCE_CYCLES counts before it is accepted
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    settled  = (settle_q == ST_W'(SETTLE));
    settle_d = settled ? settle_q : settle_q + ST_W'(1);
    one_hot  = (stable_q != 4'b0000) && ((stable_q & (stable_q - 4'd1)) == 4'b0000);
    playing  = (game_state == 2'b00);
  end

  // Next-state and registered output logic
  always_comb begin
    state_d = state_q;
    dir_d   = 4'b0000;
    mc_d    = mc_q;
`ifdef DIR_AUTOREPEAT_EN
    rpt_d    = '0;
    held_d   = held_q;
    rpt_hold = one_hot && playing && (stable_q == held_q) && (stable_d == stable_q);
`endif
    unique case (state_q)
      IDLE: begin
        if (stable_q != 4'b0000) begin
          if (one_hot && playing) state_d = FIRE;
          else                    state_d = HOLD;
        end
      end
      FIRE: state_d = HOLD;
      HOLD: begin
        if (stable_q == 4'b0000 && settled) begin
          state_d = IDLE;
        end
`ifdef DIR_AUTOREPEAT_EN
        else if (rpt_hold) begin
          if (rpt_q == RPT_W'(REPEAT_CYCLES - 1)) state_d = FIRE;
          else                                   rpt_d   = rpt_q + RPT_W'(1);
        end
`endif
      end
      default: state_d = HOLD;
    endcase

    if (state_d == FIRE) begin
      dir_d = stable_q;
      if (mc_q != 16'hFFFF) mc_d = mc_q + 16'd1;
`ifdef DIR_AUTOREPEAT_EN
      held_d = stable_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HOLD;
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      dir_q    <= '0;
      mc_q     <= '0;
      settle_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
`ifdef DIR_AUTOREPEAT_EN
      rpt_q    <= '0;
      held_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      dir_q    <= dir_d;
      mc_q     <= mc_d;
      settle_q <= settle_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
`ifdef DIR_AUTOREPEAT_EN
      rpt_q    <= rpt_d;
      held_q   <= held_d;
`endif
    end
  end

  assign direction  = dir_q;
  assign btn_stable = stable_q;
  assign move_count = mc_q;

endmodule

// File: tb/tb_button_direction_ctrl.sv
// Directed bench for button_direction_ctrl with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_button_direction_ctrl;

  localparam int unsigned DB    = 4;
  localparam int unsigned RP    = 8;
  localparam int          PRESS = 9;
`ifdef DIR_AUTOREPEAT_EN
  localparam int          T1_HOLD = 9;
`else
  localparam int          T1_HOLD = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn_raw = 4'b0000;
  logic [1:0]  game_state = 2'b00;
  logic [3:0]  direction;
  logic [3:0]  btn_stable;
  logic [15:0] move_count;

  int          checks = 0;
  int          errors = 0;
  int          pulse_total = 0;
  int          onehot_bad = 0;
  int          base = 0;
  logic [3:0]  last_dir = 4'b0000;
  logic [3:0]  exp_dir;

  always #5 clk = ~clk;

  button_direction_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .game_state(game_state),
    .direction (direction),
    .btn_stable(btn_stable),
    .move_count(move_count)
  );

  // Pulse monitor sampled mid-cycle
  always @(negedge clk) begin
    if (direction != 4'b0000) begin
      pulse_total = pulse_total + 1;
      last_dir    = direction;
      if (!$onehot(direction)) onehot_bad = onehot_bad + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_dir", 32'(direction), 32'h0);
    chk("rst_stable", 32'(btn_stable), 32'h0);
    chk("rst_mc", 32'(move_count), 32'h0);
    rst = 1'b0;
    tick(10);

    // Clean press: pulse 7 edges after the sampling edge
    base = pulse_total;
    btn_raw = 4'b1000;
    for (int k = 0; k < T1_HOLD; k++) begin
      tick(1);
      if (k == 6) chk("t1_early", 32'(direction), 32'h0);
      if (k == 7) chk("t1_pulse", 32'(direction), 32'h8);
      if (k == 8) begin
        chk("t1_single", 32'(direction), 32'h0);
        chk("t1_mc", 32'(move_count), 32'h1);
      end
    end
    btn_raw = 4'b0000;
    tick(15);
    chk("t1_pulses", 32'(pulse_total - base), 32'h1);
    chk("t1_released", 32'(btn_stable), 32'h0);

    // Bounce shorter than the debounce window
    base = pulse_total;
    for (int k = 0; k < 20; k++) begin
      btn_raw[2] = ((k / 2) % 2 == 0);
      tick(1);
      if (k == 11) chk("t2_mid_stable", 32'(btn_stable), 32'h0);
    end
    btn_raw = 4'b0000;
    tick(8);
    chk("t2_stable", 32'(btn_stable), 32'h0);
    chk("t2_pulses", 32'(pulse_total - base), 32'h0);
    chk("t2_mc", 32'(move_count), 32'h1);

    // Two buttons together, then a single press
    base = pulse_total;
    btn_raw = 4'b0011;
    tick(PRESS);
    chk("t3_stable", 32'(btn_stable), 32'h3);
    chk("t3_multi_pulses", 32'(pulse_total - base), 32'h0);
    btn_raw = 4'b0000;
    tick(12);
    btn_raw = 4'b0001;
    tick(PRESS);
    chk("t3_pulses", 32'(pulse_total - base), 32'h1);
    chk("t3_dir", 32'(last_dir), 32'h1);
    chk("t3_mc", 32'(move_count), 32'h2);
    btn_raw = 4'b0000;
    tick(12);

    // Game not playing blocks the move
    game_state = 2'b01;
    base = pulse_total;
    btn_raw = 4'b0010;
    tick(PRESS);
    chk("t4_blocked", 32'(pulse_total - base), 32'h0);
    chk("t4_blocked_mc", 32'(move_count), 32'h2);
    btn_raw = 4'b0000;
    tick(12);
    game_state = 2'b00;
    btn_raw = 4'b0010;
    tick(PRESS);
    chk("t4_pulses", 32'(pulse_total - base), 32'h1);
    chk("t4_dir", 32'(last_dir), 32'h2);
    chk("t4_mc", 32'(move_count), 32'h3);
    btn_raw = 4'b0000;
    tick(12);

    // Button held through reset release
    rst = 1'b1;
    btn_raw = 4'b0100;
    tick(3);
    chk("t5_rst_mc", 32'(move_count), 32'h0);
    chk("t5_rst_dir", 32'(direction), 32'h0);
    rst = 1'b0;
    base = pulse_total;
    tick(20);
    chk("t5_held_pulses", 32'(pulse_total - base), 32'h0);
    chk("t5_held_stable", 32'(btn_stable), 32'h4);
    btn_raw = 4'b0000;
    tick(15);
    btn_raw = 4'b0100;
    tick(PRESS);
    chk("t5_repress", 32'(pulse_total - base), 32'h1);
    chk("t5_repress_mc", 32'(move_count), 32'h1);
    btn_raw = 4'b0000;
    tick(12);

    // Reset during the pulse aborts it
    base = pulse_total;
    btn_raw = 4'b1000;
    tick(8);
    chk("t6_pulse_up", 32'(direction), 32'h8);
    #1 rst = 1'b1;
    #1;
    chk("t6_abort_dir", 32'(direction), 32'h0);
    chk("t6_abort_mc", 32'(move_count), 32'h0);
    tick(2);
    rst = 1'b0;
    btn_raw = 4'b0000;
    tick(20);
    chk("t6_residual", 32'(pulse_total - base), 32'h0);

    // Reset during debounce
    btn_raw = 4'b0001;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    btn_raw = 4'b0000;
    tick(15);
    chk("t6_db_stable", 32'(btn_stable), 32'h0);
    chk("t6_db_pulses", 32'(pulse_total - base), 32'h0);

    // Long hold: auto-repeat every 9 cycles when enabled, else one pulse
    base = pulse_total;
    btn_raw = 4'b0100;
    for (int k = 0; k < 56; k++) begin
      tick(1);
      if (k == 39) btn_raw = 4'b0000;
`ifdef DIR_AUTOREPEAT_EN
      exp_dir = (k >= 7 && k <= 45 && ((k - 7) % 9 == 0)) ? 4'b0100 : 4'b0000;
`else
      exp_dir = (k == 7) ? 4'b0100 : 4'b0000;
`endif
      chk($sformatf("t7_dir_k%0d", k), 32'(direction), 32'(exp_dir));
    end
`ifdef DIR_AUTOREPEAT_EN
    chk("t7_pulses", 32'(pulse_total - base), 32'h5);
    chk("t7_mc", 32'(move_count), 32'h5);
`else
    chk("t7_pulses", 32'(pulse_total - base), 32'h1);
    chk("t7_mc", 32'(move_count), 32'h1);
`endif
    chk("onehot", 32'(onehot_bad), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
